serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller that time-shares one 1-bit full-adder cell, built from two half_adder instances plus a carry flop.
- Adds two WIDTH-bit operands over WIDTH cycles, one bit per cycle, LSB first.
- Uses a start/busy/done handshake.
- Sits between an operand source (testbench or small datapath) and the existing half_adder primitive. It sequences the primitive instead of replicating it WIDTH times.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin an addition; sampled only in IDLE
- op_a  input  WIDTH  operand A; captured on the accepting edge
- op_b  input  WIDTH  operand B; captured on the accepting edge
- sum  output  WIDTH  registered result; held until the next DONE
- cout  output  1  registered carry-out of the MSB; held with sum
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when sum/cout become valid

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n, asynchronous, active-low.
- Reset (asserted at any time, including mid-operation):
  - state=IDLE; sum=0, cout=0, busy=0, done=0.
  - Internal shift registers, carry flop and bit counter cleared.
  - Any in-flight operation is discarded with no done pulse.
- States: IDLE, RUN, DONE (2-bit encoding from package).
- IDLE:
  - start=1 at edge k → latch op_a/op_b into shift regs, carry=0, bit_cnt=0, state→RUN, busy=1 after edge k.
  - start=0 → stay in IDLE.
- RUN, each edge:
  - bit = a_sh[0] ^ b_sh[0] ^ carry via the fa_bit cell; carry ← majority.
  - Result bit shifted into res_sh from the MSB side; a_sh, b_sh shifted right; bit_cnt++.
  - Edges k+1..k+WIDTH process bits 0..WIDTH-1.
  - At edge k+WIDTH (bit_cnt==WIDTH-1 before the edge): sum←final res_sh, cout←final carry, busy→0, done→1, state→DONE.
- DONE: single cycle; next edge → IDLE, done→0. start during DONE is ignored.
- Latency: done is high in the cycle after edge k+WIDTH; busy is high for exactly WIDTH cycles.
- start while busy or in DONE: ignored; operands are not re-latched.
- op_a/op_b may change after the accepting edge without effect.
- sum/cout do not change during RUN; they hold the previous result until the next DONE.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of the true sum.
- bit_cnt width is $clog2(WIDTH+1).
- WIDTH=1: RUN lasts one cycle.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands.
  - sub=1 → b_sh loaded with ~op_b and carry initialised to 1 (two's-complement A−B).
  - cout=1 means no borrow (A≥B unsigned).
  - sub=0 → identical to add.
- Undefined: no sub port; add only.

Decomposition:
- Package serial_adder_pkg holds:
  - state constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default width constant SA_WIDTH_DEFAULT=8.
- Sub-module fa_bit: 1-bit full adder made of two half_adder instances plus an OR for carry; ports a, b, cin, sum, cout.
- serial_adder_ctrl contains the FSM, shift registers, counter and carry flop, and instantiates one fa_bit.

Test Plan (WIDTH=8):
- Reset, then op_a=0x00, op_b=0x00, start pulse → busy high 8 cycles; done pulse 8 cycles after start edge; sum=0x00, cout=0.
- op_a=0xFF, op_b=0x01 → sum=0x00, cout=1; all 8 carry stages propagate.
- op_a=0xA5, op_b=0x5A, then start re-asserted with op_a=0x11, op_b=0x22 at cycle 3 of RUN → sum=0xFF, cout=0; second start ignored; no extra done.
- Start 0x3C+0x0F, assert rst_n=0 at cycle 4 of RUN → busy=0, done never pulses, sum=0; a subsequent 0x3C+0x0F completes with sum=0x4B.
- Back-to-back: start held high continuously with 0x01+0x01 → done every 10 cycles (IDLE, RUN×8, DONE); sum=0x02 each time.
- With SERIAL_ADDER_SUB_EN, sub=1: op_a=0x05, op_b=0x07 → sum=0xFE, cout=0; op_a=0x07, op_b=0x05 → sum=0x02, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the serial adder
package serial_adder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  localparam int SA_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/fa_bit.sv
// fa_bit: 1-bit full adder from two half adders and an OR for carry
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic s1, c1, c2;
  half_adder u_ha0 (.a(a),  .b(b),   .sum(s1),  .carry(c1));
  half_adder u_ha1 (.a(s1), .b(cin), .sum(sum), .carry(c2));
  assign cout = c1 | c2;
endmodule

// File: rtl/half_adder.sv
// half_adder: 1-bit half adder primitive
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add (or subtract with SERIAL_ADDER_SUB_EN) over WIDTH cycles, start/busy/done handshake
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nx;
  logic [CW-1:0] bit_cnt;
  logic carry, fa_s, fa_c, last, sub_i;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif
  fa_bit u_fa (.a(a_sh[0]), .b(b_sh[0]), .cin(carry), .sum(fa_s), .cout(fa_c));
  assign last   = bit_cnt == CW'(WIDTH - 1);
  assign res_nx = (WIDTH'(fa_s) << (WIDTH - 1)) | (res_sh >> 1);
  assign busy   = state == ST_RUN;
  assign done   = state == ST_DONE;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nx;
  // next state: accept in IDLE, leave RUN after the last bit, DONE lasts one cycle
  always_comb begin
    state_nx = ST_IDLE;
    state_nx = (state == ST_IDLE) ? (start ? ST_RUN : ST_IDLE) :
               (state == ST_RUN)  ? (last ? ST_DONE : ST_RUN) : ST_IDLE;
  end
  // operand capture, per-bit shift/carry, and result publish on the last bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      a_sh    <= op_a;
      b_sh    <= sub_i ? ~op_b : op_b;
      carry   <= sub_i;
      bit_cnt <= '0;
    end else if (state == ST_RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      res_sh  <= res_nx;
      carry   <= fa_c;
      bit_cnt <= bit_cnt + CW'(1);
      if (last) begin
        sum  <= res_nx;
        cout <= fa_c;
      end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed plus random checks of serial_adder_ctrl (WIDTH=8) against an arithmetic model
module tb_serial_adder_ctrl;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0, sum;
  logic cout, busy, done;
  int n_cmp = 0, n_err = 0;
  logic [W-1:0] last_sum = '0;
  logic last_cout = 1'b0;
  always #5 clk = ~clk;
  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .op_a(op_a), .op_b(op_b), .sum(sum), .cout(cout), .busy(busy), .done(done)
  );
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int unsigned r;
    r = s ? int'(a) + ((1 << W) - 1 - int'(b)) + 1 : int'(a) + int'(b);
    return r[W:0];
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int restart_at);
    logic [W:0] exp;
    exp = model(a, b, s);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
      chk("sum_hold", 32'(sum), 32'(last_sum));
      chk("cout_hold", 32'(cout), 32'(last_cout));
      start = (i == restart_at);
      if (i == restart_at) begin op_a = 8'h11; op_b = 8'h22; end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("sum", 32'(sum), 32'(exp[W-1:0]));
    chk("cout", 32'(cout), 32'(exp[W]));
    last_sum = exp[W-1:0]; last_cout = exp[W];
    @(negedge clk);
    chk("done_low", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask
  initial begin
    int last_c, pulses;
    repeat (2) @(negedge clk);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    op(8'h00, 8'h00, 1'b0, -1);
    op(8'hFF, 8'h01, 1'b0, -1);
    op(8'hA5, 8'h5A, 1'b0, 3);
    @(negedge clk);
    op_a = 8'h3C; op_b = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      pulses += int'(done);
    end
    chk("arst_no_done", 32'(pulses), 32'd0);
    last_sum = '0; last_cout = 1'b0;
    op(8'h3C, 8'h0F, 1'b0, -1);
    @(negedge clk);
    op_a = 8'h01; op_b = 8'h01; start = 1'b1;
    last_c = -1; pulses = 0;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      if (done) begin
        chk("b2b_sum", 32'(sum), 32'h02);
        if (last_c >= 0) chk("b2b_gap", 32'(c - last_c), 32'd10);
        last_c = c;
        pulses++;
      end
    end
    chk("b2b_count", 32'(pulses), 32'd3);
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("b2b_drain", 32'(busy), 32'd0);
    last_sum = 8'h02; last_cout = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    op(8'h05, 8'h07, 1'b1, -1);
    op(8'h07, 8'h05, 1'b1, -1);
`endif
    for (int t = 0; t < 6; t++) begin
`ifdef SERIAL_ADDER_SUB_EN
      op(W'($urandom), W'($urandom), 1'($urandom), -1);
`else
      op(W'($urandom), W'($urandom), 1'b0, -1);
`endif
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
